hazard_scoreboard: RTL and testbench

- Parametrised hazard unit for the in-order RISC-V pipeline. It replaces the fixed one-cycle load-use check with a per-register countdown scoreboard.
- It supports variable result latency (ALU, load, mul/div), a structural hazard for a non-pipelined mul/div unit, WAW ordering, branch flush and a saturating stall-cycle counter.
- Sits beside the ID stage; drives PC/IF-ID stall and IF-ID/ID-EX flush.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_sb_counter.sv | 32 +++
 rtl/hazard_scoreboard.sv | 125 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard scoreboard.
//   - Latency-class encodings carried by the ID-stage instruction.
//   - lat_cycles(): maps a latency class to the number of cycles a
//     dependent instruction must wait before its operand is forwardable.
package hazard_pkg;

  localparam logic [1:0] LAT_ALU    = 2'd0;
  localparam logic [1:0] LAT_LOAD   = 2'd1;
  localparam logic [1:0] LAT_MULDIV = 2'd2;
  localparam logic [1:0] LAT_RSVD   = 2'd3;

  // The reserved class behaves exactly like ALU: result ready for the
  // next instruction with no wait.
  function automatic int unsigned lat_cycles(input logic [1:0]  cls,
                                             input int unsigned load_lat,
                                             input int unsigned md_lat);
    int unsigned l;
    case (cls)
      LAT_LOAD:   l = load_lat;
      LAT_MULDIV: l = md_lat;
      default:    l = 0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/hazard_sb_counter.sv
// Single scoreboard down-counter.
//   clk, rst : clock, asynchronous active-high reset (clears to 0)
//   load     : load load_val this cycle (wins over the decrement)
//   load_val : value to load
//   cnt      : current count
//   nz       : cnt != 0
// The counter decrements by one each cycle while nonzero and stops at 0,
// so it can never wrap.
module hazard_sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         nz
);

  assign nz = |cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (nz) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown hazard unit for the in-order pipeline, sitting
// beside ID. Each architectural register (x1..NUM_REGS-1) has a counter of
// cycles until its pending result is forwardable; a separate counter
// tracks the busy, non-pipelined mul/div unit.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_valid                      valid instruction in ID
//   id_rs1/id_rs2, *_used         source registers and whether they are read
//   id_rd, id_reg_write           destination register and write enable
//   id_lat_class                  0=ALU 1=LOAD 2=MULDIV 3=reserved (as ALU)
//   branch_taken                  taken branch/jump resolved in EX
//   stall                         hold PC and IF/ID
//   flush_if_id                   squash IF/ID
//   flush_id_ex                   insert bubble into ID/EX
//   issue                         ID instruction advances to EX
//   stall_count                   saturating count of stall cycles
//
// All control outputs are combinational from the inputs and the current
// scoreboard; state updates on the rising clock edge.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic [1:0]       id_lat_class,
  input  logic             branch_taken,
  output logic             stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             issue,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MAX_LAT = (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;
  localparam int CW_RAW  = $clog2(MAX_LAT + 1);
  localparam int CW      = (CW_RAW < 1) ? 1 : CW_RAW;

  logic [CW-1:0]       cnt [NUM_REGS];
  logic [NUM_REGS-1:0] nz;
  logic [CW-1:0]       md_cnt;
  logic                md_nz;
  logic [CW-1:0]       lat_id;
  logic                raw, waw, struct_hz, hz;
  logic                rd_load, md_load;

  assign lat_id = CW'(lat_cycles(id_lat_class, LOAD_LAT, MD_LAT));

  // x0 is hardwired to zero: never tracked, never a hazard.
  assign cnt[0] = '0;
  assign nz[0]  = 1'b0;

  assign rd_load = issue & id_reg_write & (id_rd != 5'd0);
  assign md_load = issue & (id_lat_class == LAT_MULDIV);

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    hazard_sb_counter #(.W(CW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (rd_load && (id_rd == 5'(r))),
      .load_val (lat_id),
      .cnt      (cnt[r]),
      .nz       (nz[r])
    );
  end

  hazard_sb_counter #(.W(CW)) u_md_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (md_load),
    .load_val (CW'(MD_LAT)),
    .cnt      (md_cnt),
    .nz       (md_nz)
  );

  assign raw = (id_rs1_used & (id_rs1 != 5'd0) & nz[id_rs1])
             | (id_rs2_used & (id_rs2 != 5'd0) & nz[id_rs2]);

  // A younger write with a shorter latency must not retire before an
  // older pending write to the same register.
  assign waw = id_reg_write & (id_rd != 5'd0) & (cnt[id_rd] > lat_id);

  // The mul/div unit is not pipelined; a new MULDIV waits for md_cnt==0.
  assign struct_hz = (id_lat_class == LAT_MULDIV) & md_nz;

  assign hz = id_valid & (raw | waw | struct_hz);

  // A taken branch is older than ID, so it squashes ID and IF without
  // touching any scoreboard entry.
  always_comb begin
    stall       = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    issue       = 1'b0;
    if (branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else begin
      stall       = hz;
      flush_id_ex = hz;
      issue       = id_valid & ~hz;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_rs1_used, id_rs2_used, id_reg_write;
  logic [1:0]       id_lat_class;
  logic             branch_taken;
  logic             stall, flush_if_id, flush_id_ex, issue;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  // Expected {stall, flush_if_id, flush_id_ex, issue} per driven step.
  logic [3:0]       exp_q[$];
  logic [CNT_W-1:0] exp_sc;

  hazard_scoreboard #(
    .NUM_REGS(32), .LOAD_LAT(1), .MD_LAT(3), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_lat_class (id_lat_class),
    .branch_taken (branch_taken),
    .stall        (stall),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .issue        (issue),
    .stall_count  (stall_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver: apply one ID-stage cycle shortly after the rising edge, record
  // the expected control outputs, compare them mid-cycle, then advance.
  task automatic step(input string tag,
                      input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic rw, input logic [1:0] cls,
                      input logic br,
                      input logic e_stall, input logic e_fif, input logic e_fid,
                      input logic e_issue);
    logic [3:0] e;
    id_valid     = v;
    id_rs1       = rs1;
    id_rs1_used  = u1;
    id_rs2       = rs2;
    id_rs2_used  = u2;
    id_rd        = rd;
    id_reg_write = rw;
    id_lat_class = cls;
    branch_taken = br;
    exp_q.push_back({e_stall, e_fif, e_fid, e_issue});
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".ctl"}, 32'({stall, flush_if_id, flush_id_ex, issue}), 32'(e));
    chk({tag, ".sc"}, 32'(stall_count), 32'(exp_sc));
    @(posedge clk);
    #1;
    if (e_stall && !rst && exp_sc != {CNT_W{1'b1}}) exp_sc++;
  endtask

  task automatic nop(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst    = 1'b1;
    exp_sc = '0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_reg_write = 0; id_lat_class = 0; branch_taken = 0;
    @(posedge clk);
    #1;

    // Reset: cleared scoreboard, issue follows id_valid, flush follows branch.
    step("rst_issue", 1, 5, 1, 7, 1, 3, 1, 2'd2, 0, 0, 0, 0, 1);
    step("rst_br",    1, 5, 1, 0, 0, 0, 0, 2'd0, 1, 0, 1, 1, 0);
    rst = 1'b0;
    nop("idle");

    // Load-use: one stall cycle.
    step("ld_x5",     1, 0, 0, 0, 0, 5, 1, 2'd1, 0, 0, 0, 0, 1);
    step("lu_stall",  1, 5, 1, 0, 0, 6, 1, 2'd0, 0, 1, 0, 1, 0);
    step("lu_issue",  1, 5, 1, 0, 0, 6, 1, 2'd0, 0, 0, 0, 0, 1);
    nop("lu_done");

    // Mul/div RAW: three stall cycles, issue on the fourth.
    step("md_x7",     1, 0, 0, 0, 0, 7, 1, 2'd2, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step("md_raw_stall", 1, 0, 0, 7, 1, 8, 1, 2'd0, 0, 1, 0, 1, 0);
    step("md_raw_issue", 1, 0, 0, 7, 1, 8, 1, 2'd0, 0, 0, 0, 0, 1);

    // WAW: LOAD to x7 waits until cnt[7] <= LOAD_LAT.
    step("md_x7_b",   1, 0, 0, 0, 0, 7, 1, 2'd2, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++)
      step("waw_stall", 1, 0, 0, 0, 0, 7, 1, 2'd1, 0, 1, 0, 1, 0);
    step("waw_issue", 1, 0, 0, 0, 0, 7, 1, 2'd1, 0, 0, 0, 0, 1);
    nop("waw_done");

    // Structural: back-to-back MULDIV to independent registers.
    step("md_x1",     1, 0, 0, 0, 0, 1, 1, 2'd2, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step("st_stall", 1, 0, 0, 0, 0, 2, 1, 2'd2, 0, 1, 0, 1, 0);
    step("st_issue",  1, 0, 0, 0, 0, 2, 1, 2'd2, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) nop("st_drain");

    // Branch priority over a pending load-use hazard.
    step("ld_x5_b",   1, 0, 0, 0, 0, 5, 1, 2'd1, 0, 0, 0, 0, 1);
    step("br_flush",  1, 5, 1, 0, 0, 6, 1, 2'd0, 1, 0, 1, 1, 0);
    step("br_after",  1, 5, 1, 0, 0, 6, 1, 2'd0, 0, 0, 0, 0, 1);

    // x0 is never tracked.
    step("ld_x0",     1, 0, 0, 0, 0, 0, 1, 2'd1, 0, 0, 0, 0, 1);
    step("rd_x0",     1, 0, 1, 0, 1, 0, 1, 2'd2, 0, 0, 0, 0, 1);

    // Reset mid-count discards pending mul/div entries.
    for (int i = 0; i < 3; i++) nop("x0_drain");
    step("md_x9",     1, 0, 0, 0, 0, 9, 1, 2'd2, 0, 0, 0, 0, 1);
    rst    = 1'b1;
    exp_sc = '0;
    nop("rst_mid");
    rst = 1'b0;
    step("x9_read",   1, 9, 1, 0, 0, 10, 1, 2'd0, 0, 0, 0, 0, 1);
    nop("post_rst_idle");
    step("md_free",   1, 0, 0, 0, 0, 11, 1, 2'd2, 0, 0, 0, 0, 1);

    // Final report
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
